mem_nr1w_sync: RTL

Parametrised synchronous memory with `rd_ports_p` independent read ports and one write port. Each read port has its own `bsg_mem_1rw_sync` replica, and every write goes to all replicas. Unlike a fixed two-port array, read/write conflicts are resolved in hardware through valid/ready handshakes, a starvation-bounded arbiter and per-port read-data hold registers. It sits in the memsys layer under caches and tag arrays that need several lookups per cycle.

---
 rtl/memsys_pkg.sv | 20 ++
 rtl/bsg_mem_1rw_sync.sv | 44 ++++
 rtl/mem_nr1w_arb.sv | 91 +++++++++
 rtl/mem_nr1w_chk.sv | 19 +
 rtl/mem_nr1w_sync.sv | 109 ++++++++++
 5 files changed

// File: rtl/memsys_pkg.sv
// memsys_pkg: shared types and helpers for the memsys memory blocks.
//   mem_arb_state_e    : write/read priority state of the nR1W arbiter.
//   starve_width()     : width of a counter that must hold 0..limit (min 1 bit).
package memsys_pkg;

    typedef enum logic [0:0] {
        WPRIO = 1'b0,
        RPRIO = 1'b1
    } mem_arb_state_e;

    // A limit of 0 still needs a 1-bit counter so the logic stays well formed.
    function automatic int starve_width(input int limit);
        if (limit < 1) begin
            return 1;
        end else begin
            return $clog2(limit + 1);
        end
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// bsg_mem_1rw_sync: single-port synchronous RAM, one access per cycle.
//   clk_i, reset_i : clock, async active-high reset (output register only)
//   v_i, w_i       : access enable, 1 = write / 0 = read
//   addr_i, data_i : access address and write data
//   data_o         : registered read data, updated only on read accesses
// Array contents are not reset.
module bsg_mem_1rw_sync #(
    parameter int width_p = 32,
    parameter int els_p   = 16,
    localparam int addr_width_lp = $clog2(els_p)
)(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic                     v_i,
    input  logic                     w_i,
    output logic [width_p-1:0]       data_o
);

    logic [width_p-1:0] r_mem [els_p];
    logic [width_p-1:0] r_data;

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            r_mem[addr_i] <= data_i;
        end
    end

    // Read data register; holds its value on writes and idle cycles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data <= '0;
        end else if (v_i && !w_i) begin
            r_data <= r_mem[addr_i];
        end else begin
            r_data <= r_data;
        end
    end

    assign data_o = r_data;

endmodule

// File: rtl/mem_nr1w_arb.sv
// mem_nr1w_arb: write/read arbiter with bounded read starvation.
//   i_clk, i_reset : clock, async active-high reset
//   i_w_v, i_r_v   : write request, per-port read requests
//   o_w_ready      : write may be accepted this cycle
//   o_r_ready      : per-port read may be accepted this cycle
//   o_w_accept     : write accepted this cycle
//   o_r_accept     : per-port read accepted this cycle
// Writes win by default. After starve_limit_p consecutive cycles in which a
// write was taken while a read waited, one cycle is handed to the readers.
module mem_nr1w_arb
    import memsys_pkg::*;
#(
    parameter int rd_ports_p     = 2,
    parameter int starve_limit_p = 4
)(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_w_v,
    input  logic [rd_ports_p-1:0] i_r_v,
    output logic                  o_w_ready,
    output logic [rd_ports_p-1:0] o_r_ready,
    output logic                  o_w_accept,
    output logic [rd_ports_p-1:0] o_r_accept
);

    localparam int SW = starve_width(starve_limit_p);
    localparam logic [SW-1:0] LIMIT = SW'(starve_limit_p);

    mem_arb_state_e r_state;
    mem_arb_state_e w_state_n;
    logic [SW-1:0]  r_starve;
    logic [SW-1:0]  w_starve_n;
    logic           w_rd_stall;

    // Ready generation depends only on state and the write request.
    always_comb begin
        o_w_ready = 1'b1;
        o_r_ready = {rd_ports_p{~i_w_v}};
        if (r_state == RPRIO) begin
            o_w_ready = 1'b0;
            o_r_ready = {rd_ports_p{1'b1}};
        end else begin
            o_w_ready = 1'b1;
            o_r_ready = {rd_ports_p{~i_w_v}};
        end
    end

    assign o_w_accept = i_w_v & o_w_ready;
    assign o_r_accept = i_r_v & o_r_ready;
    assign w_rd_stall = |(i_r_v & ~o_r_ready);

    // Next starvation count and state; RPRIO is decided on the updated count
    // so the readers get the cycle right after the limit-th stalled cycle.
    always_comb begin
        w_starve_n = r_starve;
        w_state_n  = WPRIO;
        if (r_state == RPRIO) begin
            w_starve_n = '0;
            w_state_n  = WPRIO;
        end else begin
            if (o_w_accept && (|i_r_v)) begin
                if (r_starve != {SW{1'b1}}) begin
                    w_starve_n = r_starve + SW'(1);
                end else begin
                    w_starve_n = r_starve;
                end
            end else if (!w_rd_stall) begin
                w_starve_n = '0;
            end else begin
                w_starve_n = r_starve;
            end
            if ((starve_limit_p != 0) && (w_starve_n == LIMIT)) begin
                w_state_n = RPRIO;
            end else begin
                w_state_n = WPRIO;
            end
        end
    end

    // Arbiter state and starvation counter registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= WPRIO;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_n;
            r_starve <= w_starve_n;
        end
    end

endmodule

// File: rtl/mem_nr1w_chk.sv
// mem_nr1w_chk: protocol checker for mem_nr1w_sync.
//   i_clk, i_reset : clock, async active-high reset
//   i_w_accept     : write accepted this cycle
//   i_r_accept     : per-port read accepted this cycle
module mem_nr1w_chk #(
    parameter int rd_ports_p = 2
)(
    input logic                  i_clk,
    input logic                  i_reset,
    input logic                  i_w_accept,
    input logic [rd_ports_p-1:0] i_r_accept
);

    // The replicas share one port, so a write and a read can never coexist.
    a_no_wr_rd_overlap: assert property (
        @(posedge i_clk) disable iff (i_reset) !(i_w_accept && (|i_r_accept))
    );

endmodule

// File: rtl/mem_nr1w_sync.sv
// mem_nr1w_sync: N-read / 1-write synchronous memory built from one
// single-port replica per read port; writes are broadcast to all replicas.
//   clk_i, reset_i              : clock, async active-high reset
//   w_v_i, w_addr_i, w_data_i   : write request
//   w_ready_o                   : write accepted when w_v_i & w_ready_o
//   r_v_i, r_addr_i             : per-port read requests (packed addresses)
//   r_ready_o                   : per-port read accepted when r_v_i & r_ready_o
//   r_v_o, r_data_o             : per-port read return pulse and held data
module mem_nr1w_sync
    import memsys_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int els_p          = 16,
    parameter int rd_ports_p     = 2,
    parameter int starve_limit_p = 4,
    localparam int addr_width_lp = $clog2(els_p)
)(
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                w_v_i,
    input  logic [addr_width_lp-1:0]            w_addr_i,
    input  logic [width_p-1:0]                  w_data_i,
    output logic                                w_ready_o,
    input  logic [rd_ports_p-1:0]               r_v_i,
    input  logic [rd_ports_p*addr_width_lp-1:0] r_addr_i,
    output logic [rd_ports_p-1:0]               r_ready_o,
    output logic [rd_ports_p-1:0]               r_v_o,
    output logic [rd_ports_p*width_p-1:0]       r_data_o
);

    logic                  w_w_accept;
    logic [rd_ports_p-1:0] w_r_accept;
    logic [rd_ports_p-1:0] r_rd_v;

    mem_nr1w_arb #(
        .rd_ports_p     (rd_ports_p),
        .starve_limit_p (starve_limit_p)
    ) u_arb (
        .i_clk      (clk_i),
        .i_reset    (reset_i),
        .i_w_v      (w_v_i),
        .i_r_v      (r_v_i),
        .o_w_ready  (w_ready_o),
        .o_r_ready  (r_ready_o),
        .o_w_accept (w_w_accept),
        .o_r_accept (w_r_accept)
    );

    // Return pulse: port k read was accepted on the previous edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_v <= '0;
        end else begin
            r_rd_v <= w_r_accept;
        end
    end

    assign r_v_o = r_rd_v;

    for (genvar k = 0; k < rd_ports_p; k++) begin : g_port
        logic                     w_rep_v;
        logic [addr_width_lp-1:0] w_rep_addr;
        logic [width_p-1:0]       w_rep_data;
        logic [width_p-1:0]       r_hold;

        // Write and read are exclusive, so the write address can win the mux.
        assign w_rep_v    = w_w_accept | w_r_accept[k];
        assign w_rep_addr = w_w_accept ? w_addr_i
                                       : r_addr_i[k*addr_width_lp +: addr_width_lp];

        bsg_mem_1rw_sync #(
            .width_p (width_p),
            .els_p   (els_p)
        ) u_mem (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .data_i  (w_data_i),
            .addr_i  (w_rep_addr),
            .v_i     (w_rep_v),
            .w_i     (w_w_accept),
            .data_o  (w_rep_data)
        );

        // Hold register keeps the last returned word for this port.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_hold <= '0;
            end else if (r_rd_v[k]) begin
                r_hold <= w_rep_data;
            end else begin
                r_hold <= r_hold;
            end
        end

        assign r_data_o[k*width_p +: width_p] = r_rd_v[k] ? w_rep_data : r_hold;
    end

`ifndef DISABLE_TESTING
    mem_nr1w_chk #(
        .rd_ports_p (rd_ports_p)
    ) u_chk (
        .i_clk      (clk_i),
        .i_reset    (reset_i),
        .i_w_accept (w_w_accept),
        .i_r_accept (w_r_accept)
    );
`endif

endmodule
